// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for an N-digit common-anode
// seven-segment display. Provides a scan prescaler, tear-free frame loading,
// per-digit blanking, decimal points and an anti-ghosting guard interval.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  tick_c;
    logic                  wrap_c;

    logic [DATA_W-1:0]     pend_data_q;
    logic [NUM_DIGITS-1:0] pend_dp_q;
    logic [NUM_DIGITS-1:0] pend_blank_q;
    logic                  pend_valid_q;

    logic [DATA_W-1:0]     disp_data_q;
    logic [NUM_DIGITS-1:0] disp_dp_q;
    logic [NUM_DIGITS-1:0] disp_blank_q;

    logic [NUM_DIGITS-1:0] lz_mask_c;
    logic [3:0]            nib_c;
    logic                  dp_sel_c;
    logic                  blank_sel_c;
    logic [6:0]            dec_c;

    logic [6:0]            seg_d, seg_q;
    logic                  dp_d, dp_q;
    logic [NUM_DIGITS-1:0] an_d, an_q;
    logic                  frame_done_q;

    assign tick_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign wrap_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Prescaler and digit index; the index only moves on the terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (tick_c) begin
            cnt_q <= '0;
            idx_q <= wrap_c ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Pending/display registers: display only changes on the frame wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
        end else if (wrap_c) begin
            // A load landing on the wrap cycle bypasses the pending stage.
            if (load) begin
                disp_data_q  <= data_in;
                disp_dp_q    <= dp_in;
                disp_blank_q <= blank_in;
            end else if (pend_valid_q) begin
                disp_data_q  <= pend_data_q;
                disp_dp_q    <= pend_dp_q;
                disp_blank_q <= pend_blank_q;
            end
            pend_valid_q <= 1'b0;
        end else if (load) begin
            pend_data_q  <= data_in;
            pend_dp_q    <= dp_in;
            pend_blank_q <= blank_in;
            pend_valid_q <= 1'b1;
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic zero_above_c;

    // Leading-zero mask from the display register; digit 0 and dp digits stay lit.
    always_comb begin
        lz_mask_c    = '0;
        zero_above_c = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above_c = zero_above_c && (disp_data_q[4*k +: 4] == 4'h0);
            lz_mask_c[k] = zero_above_c && !disp_dp_q[k];
        end
    end
`else
    assign lz_mask_c = '0;
`endif

    // Select the nibble, dp and blank bits of the digit currently scanned.
    always_comb begin
        nib_c       = 4'h0;
        dp_sel_c    = 1'b0;
        blank_sel_c = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_c       = disp_data_q[4*k +: 4];
                dp_sel_c    = disp_dp_q[k];
                blank_sel_c = disp_blank_q[k] | lz_mask_c[k];
            end
        end
    end

    // Hex to active-low segments {a,b,c,d,e,f,g}.
    always_comb begin
        dec_c = 7'h7F;
        case (nib_c)
            4'h0: dec_c = 7'b0000001;
            4'h1: dec_c = 7'b1001111;
            4'h2: dec_c = 7'b0010010;
            4'h3: dec_c = 7'b0000110;
            4'h4: dec_c = 7'b1001100;
            4'h5: dec_c = 7'b0100100;
            4'h6: dec_c = 7'b0100000;
            4'h7: dec_c = 7'b0001111;
            4'h8: dec_c = 7'b0000000;
            4'h9: dec_c = 7'b0000100;
            4'hA: dec_c = 7'b0000010;
            4'hB: dec_c = 7'b1100000;
            4'hC: dec_c = 7'b0110001;
            4'hD: dec_c = 7'b1000010;
            4'hE: dec_c = 7'b0010000;
            4'hF: dec_c = 7'b0111000;
            default: dec_c = 7'h7F;
        endcase
    end

    // Next output values: dark during the guard window, anode only when blanked.
    always_comb begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = '1;
        if (cnt_q >= CNT_W'(GUARD)) begin
            an_d = ~(NUM_DIGITS'(1) << idx_q);
            if (!blank_sel_c) begin
                seg_d = dec_c;
                dp_d  = ~dp_sel_c;
            end
        end
    end

    // Output register; frame_done follows the wrapping tick by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= wrap_c;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed scoreboard bench for seven_seg_scan (4 digits, 4-cycle slots, 1 guard cycle).
module tb_seven_seg_scan;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int GD    = 1;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [3:0]  an_out;
    logic        frame_done;

    seven_seg_scan #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD),
        .GUARD     (GD),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .load      (load),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;

    // Reference state: what the display should hold and what is pending.
    logic [15:0] m_disp,  m_pend;
    logic [3:0]  m_ddp,   m_pdp;
    logic [3:0]  m_dbl,   m_pbl;
    logic        m_pv;

    logic [12:0] sb_q[$];
    string       tag_q[$];

    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'h0: dec = 7'b0000001;  4'h1: dec = 7'b1001111;
            4'h2: dec = 7'b0010010;  4'h3: dec = 7'b0000110;
            4'h4: dec = 7'b1001100;  4'h5: dec = 7'b0100100;
            4'h6: dec = 7'b0100000;  4'h7: dec = 7'b0001111;
            4'h8: dec = 7'b0000000;  4'h9: dec = 7'b0000100;
            4'hA: dec = 7'b0000010;  4'hB: dec = 7'b1100000;
            4'hC: dec = 7'b0110001;  4'hD: dec = 7'b1000010;
            4'hE: dec = 7'b0010000;  default: dec = 7'b0111000;
        endcase
    endfunction

    // Expected {an, seg, dp, frame_done} after edge number cyc since reset release.
    function automatic logic [12:0] expect_out(input int cyc);
        int          p;
        int          i;
        logic        fd;
        logic        bl;
        logic [3:0]  an;
        logic [15:0] above;
        p     = cyc % SD;
        i     = (cyc / SD) % ND;
        fd    = ((cyc % FRAME) == FRAME - 1);
        if (p < GD) return {4'hF, 7'h7F, 1'b1, fd};
        an    = 4'hF;
        an[i] = 1'b0;
        bl    = m_dbl[i];
`ifdef SEVEN_SEG_LZ_BLANK_EN
        above = m_disp >> (4 * i);
        if (i > 0 && !m_ddp[i] && above == 16'h0) bl = 1'b1;
`else
        above = 16'h0;
`endif
        if (bl) return {an, 7'h7F, 1'b1, fd};
        return {an, dec(4'((m_disp >> (4 * i)) & 16'hF)), ~m_ddp[i], fd};
    endfunction

    task automatic check_pop();
        logic [12:0] exp_v;
        logic [12:0] obs_v;
        string       tag;
        exp_v = sb_q.pop_front();
        tag   = tag_q.pop_front();
        obs_v = {an_out, seg_out, dp_out, frame_done};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s an/seg/dp/fd observed=%h_%b_%b_%b expected=%h_%b_%b_%b",
                   tag, obs_v[12:9], obs_v[8:2], obs_v[1], obs_v[0],
                   exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic model_clear();
        m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0;
        m_dbl  = '0; m_pbl  = '0; m_pv  = 1'b0;
    endtask

    task automatic reset_cycles(input int k);
        rst_n = 1'b0;
        load  = 1'b0;
        for (int c = 0; c < k; c++) begin
            sb_q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
            tag_q.push_back($sformatf("reset%0d", c));
            @(posedge clk);
            #1;
            check_pop();
        end
        rst_n = 1'b1;
        n     = 0;
        model_clear();
    endtask

    // One clock: drive inputs, queue expected output, update reference, compare.
    task automatic step(input logic ld, input logic [15:0] d,
                        input logic [3:0] dpv, input logic [3:0] blv);
        data_in  = d;
        dp_in    = dpv;
        blank_in = blv;
        load     = ld;
        sb_q.push_back(expect_out(n));
        tag_q.push_back($sformatf("cyc%0d_slot%0d_d%0d", n, n % SD, (n / SD) % ND));
        if ((n % FRAME) == FRAME - 1) begin
            if (ld) begin
                m_disp = d; m_ddp = dpv; m_dbl = blv;
            end else if (m_pv) begin
                m_disp = m_pend; m_ddp = m_pdp; m_dbl = m_pbl;
            end
            m_pv = 1'b0;
        end else if (ld) begin
            m_pend = d; m_pdp = dpv; m_pbl = blv; m_pv = 1'b1;
        end
        @(posedge clk);
        #1;
        check_pop();
        n++;
        load = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++) step(1'b0, 16'hDEAD, 4'hF, 4'hF);
    endtask

    task automatic idle_until(input int phase);
        for (int c = 0; c < FRAME && (n % FRAME) != phase; c++)
            step(1'b0, 16'hBEEF, 4'hF, 4'hF);
    endtask

    initial begin
        data_in  = '0;
        dp_in    = '0;
        blank_in = '0;
        load     = 1'b0;
        rst_n    = 1'b0;
        model_clear();

        reset_cycles(3);

        // Basic scan of 12AF, loaded at the start of the first frame
        step(1'b1, 16'h12AF, 4'h0, 4'h0);
        idle_until(0);
        idle(FRAME);

        // Tear-free: 1111 displayed, 2222 loaded while digit 2 is lit
        step(1'b1, 16'h1111, 4'h0, 4'h0);
        idle_until(0);
        idle_until(9);
        step(1'b1, 16'h2222, 4'h0, 4'h0);
        idle_until(0);
        idle(FRAME);

        // Load exactly on the wrap tick
        idle_until(FRAME - 1);
        step(1'b1, 16'h3333, 4'h0, 4'h0);
        idle(FRAME);

        // Blank digit 3, decimal point on digit 1
        step(1'b1, 16'h4444, 4'b0010, 4'b1000);
        idle_until(0);
        idle(FRAME);

        // Last load before the wrap wins
        step(1'b1, 16'h5555, 4'h0, 4'h0);
        step(1'b1, 16'h6789, 4'b0001, 4'h0);
        idle_until(0);
        idle(FRAME);

        // Zero-heavy data (exercises leading-zero suppression when enabled)
        step(1'b1, 16'h0050, 4'h0, 4'h0);
        idle_until(0);
        idle(FRAME);
        step(1'b1, 16'h0000, 4'h0, 4'h0);
        idle_until(0);
        idle(FRAME);

        // Mid-frame reset discards a pending load
        step(1'b1, 16'h1234, 4'h0, 4'h0);
        idle_until(0);
        idle(5);
        step(1'b1, 16'hABCD, 4'hF, 4'h0);
        reset_cycles(2);
        idle(2 * FRAME);

        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display. Generalises the single-digit hex decoder to a parametrised digit count.
- Adds a scan prescaler, frame-synchronous (tear-free) data loading, per-digit blanking, decimal points and an anti-ghosting guard interval.
- Sits between game/score logic and the board display pins.
- One digit is lit at a time; all outputs are registered.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- SCAN_DIV, 1000, clk cycles per digit slot (≥ GUARD+2).
- GUARD, 2, cycles at the start of each slot with all anodes off.
- CNT_W, 16, prescaler width; must satisfy 2^CNT_W > SCAN_DIV.

Ports:
- clk, in, 1: system clock; all logic on the rising edge.
- rst_n, in, 1: synchronous reset, active-low.
- data_in, in, 4*NUM_DIGITS: hex nibbles; digit k = data_in[4k+3:4k]; digit 0 is rightmost.
- dp_in, in, NUM_DIGITS: decimal point per digit, 1 = lit.
- blank_in, in, NUM_DIGITS: per-digit blank, 1 = digit dark.
- load, in, 1: capture data_in/dp_in/blank_in into the pending register.
- seg_out, out, 7: segments {a,b,c,d,e,f,g}, MSB = a, active-low.
- dp_out, out, 1: decimal point, active-low.
- an_out, out, NUM_DIGITS: anode enables, active-low, one-hot-low when lit.
- frame_done, out, 1: one-cycle pulse when the digit index wraps NUM_DIGITS-1 → 0.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - seg_out = 7'h7F, dp_out = 1, an_out = all 1s, frame_done = 0.
  - Prescaler, digit index, pending register, pending-valid flag and display register all cleared to 0.
  - Reset mid-frame abandons the frame; a pending load is discarded.
- Prescaler counts 0..SCAN_DIV-1 and wraps. Terminal count (tick) advances the digit index 0..NUM_DIGITS-1 with wrap.
- Loading:
  - load=1 captures the inputs into the pending register and sets pending-valid. A later load before the wrap overwrites it; the last one wins.
  - On the tick where the index wraps to 0, pending → display register and pending-valid clears.
  - If load=1 on that same wrap cycle, data_in goes straight to the display register and pending-valid clears.
  - The displayed contents therefore never change mid-frame.
- Decode, active-low, a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0000010, b=1100000
  - C=0110001, d=1000010, E=0010000, F=0111000
- Output register, updated every cycle from the current index i and prescaler value p:
  - If p < GUARD: an_out = all 1s, seg_out = 7'h7F, dp_out = 1.
  - Else if blank[i]: an_out[i] = 0 (other anodes 1), seg_out = 7'h7F, dp_out = 1.
  - Else: an_out[i] = 0 (others 1), seg_out = decode(nibble i), dp_out = ~dp[i].
  - Output latency: 1 cycle after the index/prescaler change.
- frame_done is asserted in the cycle after the wrapping tick, for exactly 1 cycle.
- NUM_DIGITS=1: the index stays 0 and frame_done pulses every SCAN_DIV cycles.

Optional Feature:
- Macro: SEVEN_SEG_LZ_BLANK_EN (leading-zero suppression).
- Defined:
  - Digits above the highest nonzero nibble are forced blank, OR-ed with blank_in.
  - Digit 0 is never suppressed.
  - A digit whose dp bit is set is never suppressed.
  - The suppression mask is computed from the display register, not from data_in.
- Undefined: no suppression; zeros display as 0000001.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, GUARD=1 unless noted):
- Reset: hold rst_n=0 for 3 cycles, then release → seg_out=7F, an_out=F, dp_out=1 during reset; first lit anode is 1110 with seg 0000001 (display = 0).
- Scan: load data_in=16'h12AF, wait one frame → an_out cycles 1110, 1101, 1011, 0111 (each lit 3 of 4 cycles, guard cycle = F) with seg F=0111000, A=0000010, 2=0010010, 1=1001111; frame_done pulses once per 16 cycles.
- Tear-free: with display 16'h1111, load 16'h2222 while digit 2 is lit → digits 2 and 3 still show 1 this frame; all digits show 2 after frame_done.
- Load on wrap cycle: load 16'h3333 in the exact wrap-tick cycle → the next frame shows 3 on all digits.
- Blank/dp: blank_in=4'b1000, dp_in=4'b0010 → digit 3 slot has an_out=0111 with seg=7F; digit 1 has dp_out=0; all others have dp_out=1.
- With SEVEN_SEG_LZ_BLANK_EN defined: data 16'h0050 → digits 3 and 2 dark, digits 1 and 0 show 5 and 0; data 16'h0000 → only digit 0 shows 0.
